// File: rtl/ofs_fim_eth_plat_if_pkg.sv
// Ethernet platform interface types shared by the HSSI SS and HE-HSSI sides of the RX path.
package ofs_fim_eth_plat_if_pkg;

    localparam int unsigned ETH_PACKET_WIDTH    = 64;
    localparam int unsigned ETH_RX_ERROR_WIDTH  = 6;
    localparam int unsigned ETH_SS_STS_WIDTH    = 5;
    localparam int unsigned ETH_SS_CLIENT_WIDTH = 7;
    localparam int unsigned ETH_KEEP_CNT_WIDTH  = 7;

    typedef struct packed {
        logic [ETH_SS_STS_WIDTH-1:0]    sts;
        logic [ETH_SS_CLIENT_WIDTH-1:0] client;
    } t_axis_hssi_ss_rx_tuser;

    typedef struct packed {
        logic [ETH_RX_ERROR_WIDTH-1:0] error;
    } t_axis_eth_rx_tuser;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_IN_PKT = 1'b1
    } t_rx_state;

    // Number of enabled bytes in a (zero-extended) tkeep vector.
    function automatic logic [ETH_KEEP_CNT_WIDTH-1:0] eth_keep_popcnt(input logic [63:0] keep);
        logic [ETH_KEEP_CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + ETH_KEEP_CNT_WIDTH'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/eth_axis_skid_buf.sv
// Two-entry registered skid buffer for an AXI-S style payload; ready is a flop (not full).
module eth_axis_skid_buf #(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic [PAYLOAD_W-1:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           cnt_q;
    logic [1:0]           cnt_d;
    logic                 ready_q;
    logic                 valid_q;
    logic                 push;
    logic                 pop;

    assign push = in_valid & ready_q;
    assign pop  = valid_q & out_ready;

    always_comb begin
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
            valid_q <= (cnt_d != 2'd0);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/eth_rx_ss_to_he_axis_bridge.sv
// RX bridge from the HSSI SS MAC AXI-S to the HE-HSSI AXI-S: skid buffering, EOP error map,
// tkeep framing checks and saturating delivery statistics.
module eth_rx_ss_to_he_axis_bridge
    import ofs_fim_eth_plat_if_pkg::*;
#(
    parameter int unsigned DATA_W = ETH_PACKET_WIDTH,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ss_rx_tvalid,
    output logic                   ss_rx_tready,
    input  logic [DATA_W-1:0]      ss_rx_tdata,
    input  logic [KEEP_W-1:0]      ss_rx_tkeep,
    input  logic                   ss_rx_tlast,
    input  t_axis_hssi_ss_rx_tuser ss_rx_tuser,
    output logic                   he_rx_tvalid,
    input  logic                   he_rx_tready,
    output logic [DATA_W-1:0]      he_rx_tdata,
    output logic [KEEP_W-1:0]      he_rx_tkeep,
    output logic                   he_rx_tlast,
    output t_axis_eth_rx_tuser     he_rx_tuser,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       pkt_cnt,
    output logic [CNT_W-1:0]       err_pkt_cnt,
    output logic [CNT_W-1:0]       byte_cnt,
    output logic                   proto_err
);

    localparam int unsigned ERR_W     = ETH_RX_ERROR_WIDTH;
    localparam int unsigned PAYLOAD_W = 1 + ERR_W + KEEP_W + DATA_W;
    localparam int unsigned SUM_W     = CNT_W + 1;

    logic [ERR_W-1:0]              in_err;
    logic [ERR_W-1:0]              out_err;
    logic [PAYLOAD_W-1:0]          in_payload;
    logic [PAYLOAD_W-1:0]          out_payload;
    logic                          ss_accept;
    logic                          he_accept;
    logic                          unused_tuser;
    logic [KEEP_W-1:0]             keep_inc;
    logic                          keep_bad;
    logic [ETH_KEEP_CNT_WIDTH-1:0] keep_bytes;
    logic [SUM_W-1:0]              byte_sum;

    t_rx_state        state_q, state_d;
    logic             proto_err_q;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_pkt_cnt_q, err_pkt_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    // Only client[5:0] of the EOP beat carries error status; sts and client[6] are dropped.
    assign in_err       = ss_rx_tlast ? ss_rx_tuser.client[ERR_W-1:0] : '0;
    assign unused_tuser = ^{ss_rx_tuser.sts, ss_rx_tuser.client[ETH_SS_CLIENT_WIDTH-1]};
    assign in_payload   = {ss_rx_tlast, in_err, ss_rx_tkeep, ss_rx_tdata};

    eth_axis_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ss_rx_tvalid),
        .in_ready  (ss_rx_tready),
        .in_data   (in_payload),
        .out_valid (he_rx_tvalid),
        .out_ready (he_rx_tready),
        .out_data  (out_payload)
    );

    assign {he_rx_tlast, out_err, he_rx_tkeep, he_rx_tdata} = out_payload;
    assign he_rx_tuser.error = out_err;

    assign ss_accept = ss_rx_tvalid & ss_rx_tready;
    assign he_accept = he_rx_tvalid & he_rx_tready;

    // A last-beat keep is contiguous from bit 0 iff keep & (keep+1) clears every bit.
    assign keep_inc = ss_rx_tkeep + KEEP_W'(1);

    always_comb begin
        keep_bad = 1'b0;
        if (ss_rx_tlast) begin
            keep_bad = (ss_rx_tkeep == '0) || ((ss_rx_tkeep & keep_inc) != '0);
        end else begin
            keep_bad = (ss_rx_tkeep != '1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (ss_accept) begin
            case (state_q)
                RX_IDLE:   state_d = ss_rx_tlast ? RX_IDLE : RX_IN_PKT;
                RX_IN_PKT: state_d = ss_rx_tlast ? RX_IDLE : RX_IN_PKT;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    assign keep_bytes = eth_keep_popcnt(64'(he_rx_tkeep));

    always_comb begin
        pkt_cnt_d     = pkt_cnt_q;
        err_pkt_cnt_d = err_pkt_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        byte_sum      = SUM_W'(byte_cnt_q) + SUM_W'(keep_bytes);
        if (cnt_clr) begin
            pkt_cnt_d     = '0;
            err_pkt_cnt_d = '0;
            byte_cnt_d    = '0;
        end else if (he_accept) begin
            byte_cnt_d = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
            if (he_rx_tlast) begin
                if (pkt_cnt_q != '1) begin
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end
                if ((out_err != '0) && (err_pkt_cnt_q != '1)) begin
                    err_pkt_cnt_d = err_pkt_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RX_IDLE;
            proto_err_q   <= 1'b0;
            pkt_cnt_q     <= '0;
            err_pkt_cnt_q <= '0;
            byte_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            proto_err_q   <= ss_accept & keep_bad;
            pkt_cnt_q     <= pkt_cnt_d;
            err_pkt_cnt_q <= err_pkt_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
        end
    end

    assign proto_err   = proto_err_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_pkt_cnt = err_pkt_cnt_q;
    assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_eth_rx_ss_to_he_axis_bridge.sv
// Directed bench for the SS-to-HE RX bridge: latency, error map, skid stall, tkeep checks, counters, reset.
module tb_eth_rx_ss_to_he_axis_bridge;
    import ofs_fim_eth_plat_if_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   ss_rx_tvalid = 1'b0;
    logic                   ss_rx_tready;
    logic [63:0]            ss_rx_tdata = '0;
    logic [7:0]             ss_rx_tkeep = '0;
    logic                   ss_rx_tlast = 1'b0;
    t_axis_hssi_ss_rx_tuser ss_rx_tuser = '0;
    logic                   he_rx_tvalid;
    logic                   he_rx_tready = 1'b0;
    logic [63:0]            he_rx_tdata;
    logic [7:0]             he_rx_tkeep;
    logic                   he_rx_tlast;
    t_axis_eth_rx_tuser     he_rx_tuser;
    logic                   cnt_clr = 1'b0;
    logic [31:0]            pkt_cnt;
    logic [31:0]            err_pkt_cnt;
    logic [31:0]            byte_cnt;
    logic                   proto_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int first_acc = -1;
    int last_acc = -1;
    logic [78:0] he_q[$];

    eth_rx_ss_to_he_axis_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ss_rx_tvalid (ss_rx_tvalid),
        .ss_rx_tready (ss_rx_tready),
        .ss_rx_tdata  (ss_rx_tdata),
        .ss_rx_tkeep  (ss_rx_tkeep),
        .ss_rx_tlast  (ss_rx_tlast),
        .ss_rx_tuser  (ss_rx_tuser),
        .he_rx_tvalid (he_rx_tvalid),
        .he_rx_tready (he_rx_tready),
        .he_rx_tdata  (he_rx_tdata),
        .he_rx_tkeep  (he_rx_tkeep),
        .he_rx_tlast  (he_rx_tlast),
        .he_rx_tuser  (he_rx_tuser),
        .cnt_clr      (cnt_clr),
        .pkt_cnt      (pkt_cnt),
        .err_pkt_cnt  (err_pkt_cnt),
        .byte_cnt     (byte_cnt),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    // Records SS accept timing and every HE-side handshake as {last, error, keep, data}.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ss_rx_tvalid && ss_rx_tready) begin
            acc_cnt = acc_cnt + 1;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (he_rx_tvalid && he_rx_tready) begin
            he_q.push_back({he_rx_tlast, he_rx_tuser.error, he_rx_tkeep, he_rx_tdata});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog sim time expired");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge right after the beat is accepted.
    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [6:0] cl);
        int n = 0;
        ss_rx_tvalid       = 1'b1;
        ss_rx_tdata        = d;
        ss_rx_tkeep        = k;
        ss_rx_tlast        = l;
        ss_rx_tuser.client = cl;
        ss_rx_tuser.sts    = 5'h1F;
        while (!ss_rx_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ss_rx_tready) begin
            errors++;
            $display("FAIL push_timeout ss_rx_tready got %0b exp 1 after %0d cycles", ss_rx_tready, n);
        end
        @(negedge clk);
        ss_rx_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({he_rx_tvalid, ss_rx_tready, proto_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl {tvalid,tready,proto_err} got %b exp 000", {he_rx_tvalid, ss_rx_tready, proto_err});
        end
        checks++;
        if ({pkt_cnt, err_pkt_cnt, byte_cnt} !== 96'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h %h %h exp 0", pkt_cnt, err_pkt_cnt, byte_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ss_rx_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", ss_rx_tready);
        end
    endtask

    task automatic test_single_beat();
        he_rx_tready = 1'b1;
        push(64'h0123_4567_89AB_CDEF, 8'h3F, 1'b1, 7'h04);
        checks++;
        if ({he_rx_tvalid, he_rx_tlast, he_rx_tuser.error, he_rx_tkeep, he_rx_tdata} !==
            {1'b1, 1'b1, 6'h04, 8'h3F, 64'h0123_4567_89AB_CDEF}) begin
            errors++;
            $display("FAIL single_beat got v%b l%b e%h k%h d%h exp v1 l1 e04 k3f d0123456789abcdef",
                     he_rx_tvalid, he_rx_tlast, he_rx_tuser.error, he_rx_tkeep, he_rx_tdata);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL single_proto_err got %b exp 0", proto_err);
        end
        @(negedge clk);
        checks++;
        if ({pkt_cnt, err_pkt_cnt, byte_cnt} !== {32'd1, 32'd1, 32'd6}) begin
            errors++;
            $display("FAIL single_cnt got pkt %0d err %0d byte %0d exp 1 1 6", pkt_cnt, err_pkt_cnt, byte_cnt);
        end
    endtask

    task automatic test_multi_beat();
        he_q.delete();
        push(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 7'h7F);
        push(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 7'h7F);
        push(64'h3333_3333_3333_3333, 8'hFF, 1'b1, 7'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (he_q.size() != 3 ||
            he_q[0] !== {1'b0, 6'h00, 8'hFF, 64'h1111_1111_1111_1111} ||
            he_q[1] !== {1'b0, 6'h00, 8'hFF, 64'h2222_2222_2222_2222} ||
            he_q[2] !== {1'b1, 6'h00, 8'hFF, 64'h3333_3333_3333_3333}) begin
            errors++;
            $display("FAIL multi_beats got %0d beats, first %h exp 3 beats error 0", he_q.size(),
                     (he_q.size() > 0) ? he_q[0] : 79'h0);
        end
        checks++;
        if ({pkt_cnt, err_pkt_cnt, byte_cnt} !== {32'd2, 32'd1, 32'd30}) begin
            errors++;
            $display("FAIL multi_cnt got pkt %0d err %0d byte %0d exp 2 1 30", pkt_cnt, err_pkt_cnt, byte_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic        saw_low = 1'b0;
        int          a0 = 0;
        int          stall_acc = 0;
        int          bad_idx = -1;
        logic [78:0] exp_e;
        he_q.delete();
        first_acc = -1;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    push(64'hB000_0000_0000_0000 | 64'(i), 8'hFF, (i % 10) == 9, 7'h00);
                end
            end
            begin
                repeat (30) @(negedge clk);
                he_rx_tready = 1'b0;
                a0 = acc_cnt;
                repeat (5) begin
                    @(negedge clk);
                    if (!ss_rx_tready) saw_low = 1'b1;
                end
                stall_acc = acc_cnt - a0;
                he_rx_tready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        checks++;
        if (!saw_low || stall_acc > 2) begin
            errors++;
            $display("FAIL b2b_backpressure got tready_low %b accepts %0d exp 1 and <=2", saw_low, stall_acc);
        end
        for (int i = 0; i < 100 && i < he_q.size(); i++) begin
            exp_e = {1'((i % 10) == 9), 6'h00, 8'hFF, 64'hB000_0000_0000_0000 | 64'(i)};
            if (bad_idx < 0 && he_q[i] !== exp_e) bad_idx = i;
        end
        checks++;
        if (he_q.size() != 100 || bad_idx >= 0) begin
            errors++;
            $display("FAIL b2b_order got %0d beats first bad index %0d exp 100 in order", he_q.size(), bad_idx);
        end
        checks++;
        if (last_acc - first_acc != 104) begin
            errors++;
            $display("FAIL b2b_rate accept span got %0d exp 104", last_acc - first_acc);
        end
        checks++;
        if ({pkt_cnt, err_pkt_cnt, byte_cnt} !== {32'd12, 32'd1, 32'd830}) begin
            errors++;
            $display("FAIL b2b_cnt got pkt %0d err %0d byte %0d exp 12 1 830", pkt_cnt, err_pkt_cnt, byte_cnt);
        end
    endtask

    task automatic test_keep_err();
        push(64'hF0F0_0000_0000_0001, 8'hF0, 1'b0, 7'h00);
        checks++;
        if (proto_err !== 1'b1 || he_rx_tvalid !== 1'b1 || he_rx_tkeep !== 8'hF0 ||
            he_rx_tdata !== 64'hF0F0_0000_0000_0001) begin
            errors++;
            $display("FAIL keep_nonlast got perr %b v %b k %h d %h exp 1 1 f0 f0f0000000000001",
                     proto_err, he_rx_tvalid, he_rx_tkeep, he_rx_tdata);
        end
        push(64'hF0F0_0000_0000_0002, 8'hFF, 1'b1, 7'h00);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL keep_pulse_width got %b exp 0", proto_err);
        end
        push(64'hF0F0_0000_0000_0003, 8'h00, 1'b1, 7'h00);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL keep_last_zero got %b exp 1", proto_err);
        end
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b0 || pkt_cnt !== 32'd14 || byte_cnt !== 32'd842) begin
            errors++;
            $display("FAIL keep_after got perr %b pkt %0d byte %0d exp 0 14 842", proto_err, pkt_cnt, byte_cnt);
        end
    endtask

    task automatic test_saturation();
        force dut.byte_cnt_q = 32'hFFFF_FFFC;
        force dut.pkt_cnt_q  = 32'hFFFF_FFFF;
        #1;
        release dut.byte_cnt_q;
        release dut.pkt_cnt_q;
        push(64'hCAFE_F00D_0000_0001, 8'hFF, 1'b1, 7'h01);
        @(negedge clk);
        checks++;
        if ({pkt_cnt, err_pkt_cnt, byte_cnt} !== {32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL saturate got pkt %h err %0d byte %h exp ffffffff 2 ffffffff", pkt_cnt, err_pkt_cnt, byte_cnt);
        end
    endtask

    task automatic test_cnt_clr();
        push(64'h0D0D_0D0D_0D0D_0D0D, 8'h0F, 1'b1, 7'h02);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if ({pkt_cnt, err_pkt_cnt, byte_cnt} !== 96'h0) begin
            errors++;
            $display("FAIL cnt_clr got pkt %h err %h byte %h exp 0", pkt_cnt, err_pkt_cnt, byte_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        he_rx_tready = 1'b1;
        push(64'hAAAA_0000_0000_0000, 8'hFF, 1'b1, 7'h00);
        @(negedge clk);
        checks++;
        if (pkt_cnt !== 32'd1 || byte_cnt !== 32'd8) begin
            errors++;
            $display("FAIL rstmid_pre got pkt %0d byte %0d exp 1 8", pkt_cnt, byte_cnt);
        end
        he_rx_tready = 1'b0;
        push(64'hE100_0000_0000_0001, 8'hFF, 1'b0, 7'h00);
        push(64'hE200_0000_0000_0002, 8'hFF, 1'b0, 7'h00);
        checks++;
        if (he_rx_tvalid !== 1'b1 || ss_rx_tready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full got tvalid %b tready %b exp 1 0", he_rx_tvalid, ss_rx_tready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (he_rx_tvalid !== 1'b0 || ss_rx_tready !== 1'b0 || {pkt_cnt, byte_cnt} !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_async got tvalid %b tready %b pkt %0d byte %0d exp 0 0 0 0",
                     he_rx_tvalid, ss_rx_tready, pkt_cnt, byte_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        he_q.delete();
        he_rx_tready = 1'b1;
        push(64'hF100_0000_0000_00F1, 8'h01, 1'b1, 7'h03);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_perr got %b exp 0", proto_err);
        end
        @(negedge clk);
        checks++;
        if (he_q.size() != 1 || he_q[0] !== {1'b1, 6'h03, 8'h01, 64'hF100_0000_0000_00F1}) begin
            errors++;
            $display("FAIL rstmid_beat got %0d beats first %h exp 1 beat", he_q.size(),
                     (he_q.size() > 0) ? he_q[0] : 79'h0);
        end
        checks++;
        if ({pkt_cnt, err_pkt_cnt, byte_cnt} !== {32'd1, 32'd1, 32'd1} || dut.state_q !== RX_IDLE) begin
            errors++;
            $display("FAIL rstmid_cnt got pkt %0d err %0d byte %0d state %0d exp 1 1 1 0",
                     pkt_cnt, err_pkt_cnt, byte_cnt, dut.state_q);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_back_to_back();
        test_keep_err();
        test_saturation();
        test_cnt_clr();
        test_reset_mid_packet();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
